rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- Parametrised round-robin arbiter granting one of NUM_CH peripheral RX FIFOs access to the FT601 read path.
- Urgent (almost-full) channels take strict precedence over normal requesters.
- A grant is held for a bounded burst of words, then released and the rotation pointer advanced.
- Replaces the fixed 8-channel arbiter; adds per-channel masking, burst limits, urgent preemption and a registered one-hot/index grant with an explicit valid.

Parameters:
- NUM_CH, 8: number of peripheral channels; 1..32, not necessarily a power of two.
- MAX_BURST, 16: maximum words transferred per grant; >= 1.
- URGENT_EN, 1: 1 = urgent inputs override normal requests; 0 = urgent ignored.
- IDX_W, max(1,$clog2(NUM_CH)): derived width of the channel index.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CH  per-channel request (RX FIFO not empty).
- urgent  in  NUM_CH  per-channel urgent flag (RX FIFO almost full).
- ch_mask  in  NUM_CH  1 = channel disabled, never granted.
- xfer  in  1  one word taken from the granted channel this cycle.
- xfer_last  in  1  consumer ends the burst with this word; qualified by xfer.
- grant_valid  out  1  a grant is active.
- grant_idx  out  IDX_W  granted channel number.
- grant_onehot  out  NUM_CH  one-hot grant; all zero when grant_valid=0.
- beat_cnt  out  $clog2(MAX_BURST+1)  words transferred in the current grant.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, beat_cnt=0, rotation pointer ptr=0.
  - Takes effect immediately, including mid-burst; no completion of the in-flight burst.
- Eligibility:
  - elig = req & ~ch_mask.
  - If URGENT_EN and |(urgent & elig), then cand = urgent & elig; else cand = elig.
- Pick: the lowest channel index at or after ptr among cand, searching ptr, ptr+1, …, NUM_CH-1, 0, … (modulo NUM_CH, correct for non-power-of-two).
- IDLE state:
  - If cand != 0: go to GRANT; register grant_idx=pick, grant_onehot=1<<pick, grant_valid=1, beat_cnt=0.
  - Latency is one clock from the req edge to grant_valid.
  - If cand == 0: stay in IDLE with outputs at reset values (grant_idx holds its last value).
- GRANT state:
  - xfer=1 increments beat_cnt.
  - xfer asserted in IDLE is ignored.
- Release conditions, any one of which causes release at the next edge:
  - (a) xfer & xfer_last.
  - (b) xfer with beat_cnt == MAX_BURST-1 (burst limit).
  - (c) !req[grant_idx] with xfer=0 (channel drained).
  - (d) ch_mask[grant_idx]=1 (channel disabled mid-grant).
  - (e) URGENT_EN, granted channel not urgent, another eligible channel urgent, and xfer=1 (preempt on a word boundary).
- On release:
  - state=IDLE, grant_valid=0, grant_onehot=0, beat_cnt=0.
  - ptr = grant_idx+1, wrapping NUM_CH-1 -> 0.
  - This gives a mandatory one-cycle bubble between grants.
- Simultaneous release conditions: still a single release; ptr advances once.
- MAX_BURST=1: every xfer releases.
- NUM_CH=1: ptr stays 0; channel 0 is re-granted after each bubble.
- beat_cnt never exceeds MAX_BURST-1 while granted.
- Invariant: grant_onehot has at most one bit set and equals 1<<grant_idx when grant_valid=1.

Decomposition:
- Shared package arb_pkg:
  - state enum arb_state_t {IDLE, GRANT}.
  - Function clog2_min1 for index widths.
  - Reused by future TX-side arbiters.
- Combinational sub-module rr_pick (params NUM_CH, IDX_W):
  - Inputs cand, ptr; outputs pick, any.
  - Implemented as a double-width rotate plus priority encode.
  - Supersedes the separate barrel_shifter/priority_encoder pair.

Test Plan:
- Reset mid-burst: NUM_CH=8, grant on ch3, beat_cnt=2, pull rst_n low asynchronously -> outputs zero before the next clk edge; ptr=0 after release.
- Round-robin: req=8'hFF, ptr=0, MAX_BURST=4, xfer held high -> grants 0,1,2,…,7,0 with 4 beats each and a 1-cycle bubble between grants.
- Urgent priority and preemption: ch2 granted (non-urgent), urgent[6] rises with req[6]=1 -> release after the next xfer; following grant_idx=6.
- Drain and mask: ch5 granted, req[5] drops with xfer=0 -> grant_valid=0 next cycle, ptr=6. Separately, ch_mask[5]=1 while granted -> same release.
- Non-power-of-two wrap: NUM_CH=5, ptr=4, req=5'b00011 -> grant ch0, then ch1; grant_idx never exceeds 4.
- Burst limit vs xfer_last: MAX_BURST=4; xfer_last on the 2nd beat -> release with beat_cnt=1 at the release edge. Without xfer_last -> release on the 4th beat.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers for the FT601 read/write path arbiters.
package arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // A one-channel arbiter still needs a 1-bit index port.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between the RX FIFO channels, the read consumer and the arbiter.
interface rr_burst_arbiter_if
   import arb_pkg::*;
#(
   parameter int NUM_CH    = 8,
   parameter int MAX_BURST = 16,
   parameter int IDX_W     = clog2_min1(NUM_CH),
   parameter int BW        = $clog2(MAX_BURST + 1)
);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] urgent;
   logic [NUM_CH-1:0] ch_mask;
   logic              xfer;
   logic              xfer_last;

   logic              grant_valid;
   logic [IDX_W-1:0]  grant_idx;
   logic [NUM_CH-1:0] grant_onehot;
   logic [BW-1:0]     beat_cnt;

   modport master (
      input  req, urgent, ch_mask, xfer, xfer_last,
      output grant_valid, grant_idx, grant_onehot, beat_cnt
   );

   modport slave (
      output req, urgent, ch_mask, xfer, xfer_last,
      input  grant_valid, grant_idx, grant_onehot, beat_cnt
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of cand at or after ptr, wrapping modulo NUM_CH.
module rr_pick #(
   parameter int NUM_CH = 8,
   parameter int IDX_W  = 3
) (
   input  logic [NUM_CH-1:0] cand_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [IDX_W-1:0]  pick_o,
   output logic              any_o
);

   localparam logic [IDX_W:0] NCH = (IDX_W + 1)'(NUM_CH);

   logic [NUM_CH-1:0] rot;
   logic [IDX_W-1:0]  off;
   logic [IDX_W:0]    sum;

   // Doubling the vector makes the rotate wrap correctly for any NUM_CH.
   assign rot   = NUM_CH'({cand_i, cand_i} >> ptr_i);
   assign any_o = |cand_i;

   always_comb begin
      off = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      sum = {1'b0, ptr_i} + {1'b0, off};
      if (sum >= NCH) sum = sum - NCH;
      pick_o = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter for the FT601 read path with urgent preemption and masking.
module rr_burst_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_CH    = 8,
   parameter int MAX_BURST = 16,
   parameter int URGENT_EN = 1,
   parameter int IDX_W     = clog2_min1(NUM_CH)
) (
   input logic                 clk,
   input logic                 rst_n,
   rr_burst_arbiter_if.master  bus
);

   localparam int               BW        = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]    BEAT_LAST = BW'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
   localparam logic             URG_ON    = (URGENT_EN != 0);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [NUM_CH-1:0] onehot_q, onehot_d;
   logic [BW-1:0]     beat_q, beat_d;

   logic [NUM_CH-1:0] elig, urg_elig, cand;
   logic [IDX_W-1:0]  pick;
   logic              any, rel;

   assign elig     = bus.req & ~bus.ch_mask;
   assign urg_elig = bus.urgent & elig;
   assign cand     = (URG_ON && (|urg_elig)) ? urg_elig : elig;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .cand_i (cand),
      .ptr_i  (ptr_q),
      .pick_o (pick),
      .any_o  (any)
   );

   // Preemption waits for a word boundary so no transfer is split.
   always_comb begin
      rel = 1'b0;
      if (state_q == GRANT) begin
         rel = (bus.xfer & bus.xfer_last)
             | (bus.xfer & (beat_q == BEAT_LAST))
             | (~bus.req[idx_q] & ~bus.xfer)
             | bus.ch_mask[idx_q]
             | (URG_ON & ~bus.urgent[idx_q] & (|(urg_elig & ~onehot_q)) & bus.xfer);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      onehot_d = onehot_q;
      beat_d   = beat_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               state_d        = GRANT;
               idx_d          = pick;
               onehot_d       = '0;
               onehot_d[pick] = 1'b1;
               beat_d         = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               state_d  = IDLE;
               onehot_d = '0;
               beat_d   = '0;
               ptr_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else if (bus.xfer) begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         ptr_q    <= '0;
         onehot_q <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         onehot_q <= onehot_d;
         beat_q   <= beat_d;
      end
   end

   assign bus.grant_valid  = (state_q == GRANT);
   assign bus.grant_idx    = idx_q;
   assign bus.grant_onehot = onehot_q;
   assign bus.beat_cnt     = beat_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: two configurations against a queue-free behavioural model.
module tb_rr_burst_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   rr_burst_arbiter_if #(.NUM_CH(8), .MAX_BURST(4)) ifa ();
   rr_burst_arbiter_if #(.NUM_CH(5), .MAX_BURST(2)) ifb ();

   rr_burst_arbiter #(.NUM_CH(8), .MAX_BURST(4), .URGENT_EN(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   rr_burst_arbiter #(.NUM_CH(5), .MAX_BURST(2), .URGENT_EN(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   typedef struct packed {
      logic v;
      int   idx;
      int   beat;
      int   ptr;
   } mst_t;

   int   checks   = 0;
   int   failures = 0;
   bit   chk_en   = 1'b0;
   mst_t ma       = '0;
   mst_t mb       = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Next grant state straight from the arbitration rules.
   function automatic mst_t mstep(input mst_t s, input int n, input int mbst, input bit uen,
                                  input logic [31:0] rq, input logic [31:0] ur,
                                  input logic [31:0] mk, input logic x, input logic xl);
      mst_t        r;
      logic [31:0] el, uc, cd;
      bit          found, rel;
      r  = s;
      el = rq & ~mk & ((n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1));
      uc = ur & el;
      cd = (uen && uc != 0) ? uc : el;
      if (!s.v) begin
         found = 1'b0;
         for (int k = 0; k < n; k++) begin
            if (!found && cd[(s.ptr + k) % n]) begin
               found  = 1'b1;
               r.v    = 1'b1;
               r.idx  = (s.ptr + k) % n;
               r.beat = 0;
            end
         end
      end else begin
         rel = (x && xl) || (x && s.beat == mbst - 1) || (!rq[s.idx] && !x) || mk[s.idx]
            || (uen && !ur[s.idx] && ((uc & ~(32'd1 << s.idx)) != 0) && x);
         if (rel) begin
            r.v    = 1'b0;
            r.beat = 0;
            r.ptr  = (s.idx + 1) % n;
         end else if (x) begin
            r.beat = s.beat + 1;
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= '0;
         mb <= '0;
      end else begin
         ma <= mstep(ma, 8, 4, 1'b1, 32'(ifa.req), 32'(ifa.urgent), 32'(ifa.ch_mask),
                     ifa.xfer, ifa.xfer_last);
         mb <= mstep(mb, 5, 2, 1'b0, 32'(ifb.req), 32'(ifb.urgent), 32'(ifb.ch_mask),
                     ifb.xfer, ifb.xfer_last);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_valid",  int'(ifa.grant_valid),  int'(ma.v));
         chk("a_idx",    int'(ifa.grant_idx),    ma.idx);
         chk("a_onehot", int'(ifa.grant_onehot), ma.v ? int'(32'd1 << ma.idx) : 0);
         chk("a_beat",   int'(ifa.beat_cnt),     ma.beat);
         chk("b_valid",  int'(ifb.grant_valid),  int'(mb.v));
         chk("b_idx",    int'(ifb.grant_idx),    mb.idx);
         chk("b_onehot", int'(ifb.grant_onehot), mb.v ? int'(32'd1 << mb.idx) : 0);
         chk("b_beat",   int'(ifb.beat_cnt),     mb.beat);
      end
   end

   task automatic tk();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string name, input int v, input int idx);
      chk({name, "_valid"}, int'(ifa.grant_valid), v);
      if (v != 0) chk({name, "_idx"}, int'(ifa.grant_idx), idx);
   endtask

   initial begin
      ifa.req = '0; ifa.urgent = '0; ifa.ch_mask = '0; ifa.xfer = 1'b0; ifa.xfer_last = 1'b0;
      ifb.req = '0; ifb.urgent = '0; ifb.ch_mask = '0; ifb.xfer = 1'b0; ifb.xfer_last = 1'b0;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_valid",  int'(ifa.grant_valid),  0);
      chk("rst_idx",    int'(ifa.grant_idx),    0);
      chk("rst_onehot", int'(ifa.grant_onehot), 0);
      chk("rst_beat",   int'(ifa.beat_cnt),     0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tk();

      // Round robin, 4-beat bursts with a bubble between grants.
      ifa.req = 8'hFF; ifa.xfer = 1'b1;
      for (int g = 0; g < 9; g++) begin
         for (int c = 0; c < 4; c++) begin
            tk();
            chk_a("rr", 1, g % 8);
            chk("rr_beat", int'(ifa.beat_cnt), c);
         end
         tk();
         chk("rr_bubble", int'(ifa.grant_valid), 0);
      end
      ifa.req = '0; ifa.xfer = 1'b0;

      // Urgent preemption only on a transferred word.
      ifa.req = 8'h04; tk(); chk_a("urg_g2", 1, 2);
      ifa.req = 8'h44; ifa.urgent = 8'h40; tk(); chk_a("urg_hold", 1, 2);
      ifa.xfer = 1'b1; tk(); chk_a("urg_rel", 0, 0);
      chk("urg_model_ptr", ma.ptr, 3);
      ifa.xfer = 1'b0; tk(); chk_a("urg_g6", 1, 6);
      ifa.req = '0; ifa.urgent = '0; tk(); chk_a("urg_drain", 0, 0);

      // Drain release then pointer check.
      ifa.req = 8'h20; tk(); chk_a("drain_g5", 1, 5);
      ifa.req = '0; tk(); chk_a("drain_rel", 0, 0);
      chk("drain_model_ptr", ma.ptr, 6);
      ifa.req = 8'h60; tk(); chk_a("drain_ptr", 1, 6);
      ifa.req = '0; tk();

      // Mask release.
      ifa.req = 8'h20; tk(); chk_a("mask_g5", 1, 5);
      ifa.ch_mask = 8'h20; tk(); chk_a("mask_rel", 0, 0);
      ifa.ch_mask = '0; ifa.req = 8'h60; tk(); chk_a("mask_ptr", 1, 6);
      ifa.req = '0; tk();

      // xfer_last on the second beat.
      ifa.req = 8'h01; tk(); chk_a("last_g0", 1, 0);
      ifa.xfer = 1'b1; tk(); chk("last_beat1", int'(ifa.beat_cnt), 1);
      ifa.xfer_last = 1'b1; tk(); chk_a("last_rel", 0, 0);
      chk("last_beat_clr", int'(ifa.beat_cnt), 0);
      ifa.xfer = 1'b0; ifa.xfer_last = 1'b0; tk(); chk_a("last_regrant", 1, 0);
      ifa.req = '0; tk();

      // Asynchronous reset mid-burst.
      ifa.req = 8'h08; tk(); chk_a("arst_g3", 1, 3);
      ifa.xfer = 1'b1; tk(); tk();
      chk("arst_beat2", int'(ifa.beat_cnt), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid",  int'(ifa.grant_valid),  0);
      chk("arst_idx",    int'(ifa.grant_idx),    0);
      chk("arst_onehot", int'(ifa.grant_onehot), 0);
      chk("arst_beat",   int'(ifa.beat_cnt),     0);
      @(negedge clk);
      rst_n = 1'b1;
      ifa.xfer = 1'b0; ifa.req = 8'hFF;
      tk(); chk_a("arst_ptr0", 1, 0);
      ifa.req = '0; tk();

      // Non-power-of-two wrap on the 5-channel instance.
      ifb.req = 5'b01000; tk(); chk("np2_g3", int'(ifb.grant_idx), 3);
      ifb.req = '0; tk(); chk("np2_rel", int'(ifb.grant_valid), 0);
      chk("np2_model_ptr", mb.ptr, 4);
      ifb.req = 5'b00011; tk(); chk("np2_wrap", int'(ifb.grant_idx), 0);
      ifb.xfer = 1'b1; tk(); chk("np2_beat", int'(ifb.beat_cnt), 1);
      tk(); chk("np2_limit", int'(ifb.grant_valid), 0);
      ifb.xfer = 1'b0; tk(); chk("np2_next", int'(ifb.grant_idx), 1);
      ifb.req = '0; tk();
      ifb.req = 5'b10001; ifb.urgent = 5'b00001; tk();
      chk("b_urg_off", int'(ifb.grant_idx), 4);
      ifb.req = '0; ifb.urgent = '0; tk();

      // Randomised traffic on both instances.
      for (int i = 0; i < 2000; i++) begin
         ifa.req       = 8'($urandom | $urandom);
         ifa.urgent    = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
         ifa.ch_mask   = ($urandom_range(0, 7) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
         ifa.xfer      = ($urandom_range(0, 9) < 7);
         ifa.xfer_last = ($urandom_range(0, 5) == 0);
         ifb.req       = 5'($urandom | $urandom);
         ifb.urgent    = 5'($urandom);
         ifb.ch_mask   = ($urandom_range(0, 7) == 0) ? 5'($urandom & $urandom) : 5'h00;
         ifb.xfer      = ($urandom_range(0, 9) < 7);
         ifb.xfer_last = ($urandom_range(0, 5) == 0);
         if (i == 977) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         tk();
      end

      @(negedge clk);
      #1 chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
